drv_pwm_cap: RTL and testbench

Capture-side counterpart of the team's PWM output driver. It samples an external PWM line and measures the high time and the full period, both in i_clk cycles, from rising edge to rising edge. A one-cycle valid strobe publishes each complete measurement. It flags a timeout when the line is stuck (0 % / 100 % duty or no signal) and reports the stuck level. Typical uses: servo/fan tach inputs and loopback checking of PWM outputs.

---
 rtl/drv_pwm_cap.sv | 98 +++++++++
 tb/tb_drv_pwm_cap.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/drv_pwm_cap.sv
// drv_pwm_cap: measures high time and rise-to-rise period of an asynchronous PWM line
// and flags a stuck line with its level.
module drv_pwm_cap #(
    parameter int p_depth = 10,
    parameter int p_sync  = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_drv_port,
    output logic [p_depth-1:0] o_high,
    output logic [p_depth-1:0] o_period,
    output logic               o_valid,
    output logic               o_timeout,
    output logic               o_level
);
    typedef enum logic [1:0] {WAIT_LOW, WAIT_RISE, MEAS_HIGH, MEAS_LOW} state_t;
    localparam logic [p_depth-1:0] c_max = '1;
    localparam logic [p_depth-1:0] c_one = p_depth'(1);

    state_t             state_q, state_d;
    logic [p_sync-1:0]  sync_q;
    logic               s_dly_q;
    logic [p_depth-1:0] per_q, per_d, hi_q, hi_d, high_d, period_d;
    logic               valid_d, timeout_d, level_d;
    logic               s, rise, fall, tmo;

    assign s    = sync_q[p_sync-1];
    assign rise = s & ~s_dly_q;
    assign fall = ~s & s_dly_q;
    // a rise in the same cycle as the saturated count still closes the period
    assign tmo  = (state_q == MEAS_HIGH || state_q == MEAS_LOW) && per_q == c_max && !rise;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= WAIT_LOW;
            sync_q    <= '0;
            s_dly_q   <= 1'b0;
            per_q     <= '0;
            hi_q      <= '0;
            o_high    <= '0;
            o_period  <= '0;
            o_valid   <= 1'b0;
            o_timeout <= 1'b0;
            o_level   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= {sync_q[p_sync-2:0], i_drv_port};
            s_dly_q   <= s;
            per_q     <= per_d;
            hi_q      <= hi_d;
            o_high    <= high_d;
            o_period  <= period_d;
            o_valid   <= valid_d;
            o_timeout <= timeout_d;
            o_level   <= level_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_LOW:  state_d = s ? WAIT_LOW : WAIT_RISE;
            WAIT_RISE: state_d = rise ? MEAS_HIGH : WAIT_RISE;
            MEAS_HIGH: state_d = tmo ? (s ? WAIT_LOW : WAIT_RISE) : (fall ? MEAS_LOW : MEAS_HIGH);
            MEAS_LOW:  state_d = tmo ? (s ? WAIT_LOW : WAIT_RISE) : (rise ? MEAS_HIGH : MEAS_LOW);
            default:   state_d = WAIT_LOW;
        endcase
    end

    always_comb begin
        per_d     = per_q;
        hi_d      = hi_q;
        high_d    = o_high;
        period_d  = o_period;
        valid_d   = 1'b0;
        timeout_d = o_timeout;
        level_d   = o_level;
        if (state_q == WAIT_RISE && rise) begin
            per_d = c_one;
            hi_d  = c_one;
        end else if (tmo) begin
            timeout_d = 1'b1;
            level_d   = s;
        end else if (state_q == MEAS_HIGH) begin
            per_d = per_q + c_one;
            hi_d  = fall ? hi_q : hi_q + c_one;
        end else if (state_q == MEAS_LOW && rise) begin
            period_d  = per_q;
            high_d    = hi_q;
            valid_d   = 1'b1;
            timeout_d = 1'b0;
            per_d     = c_one;
            hi_d      = c_one;
        end else if (state_q == MEAS_LOW) begin
            per_d = per_q + c_one;
        end
    end
endmodule

// File: tb/tb_drv_pwm_cap.sv
// tb_drv_pwm_cap: random and directed PWM stimulus on two capture instances (2 and 3 sync
// stages) checked every cycle against a timestamp-based model of the line.
module tb_drv_pwm_cap;
    localparam int c_tmo = 15;

    logic       clk = 1'b0, rst = 1'b1, drv = 1'b0;
    logic [3:0] high2, per2, high3, per3;
    logic       val2, to2, lv2, val3, to3, lv3;
    int         n_cmp = 0, n_bad = 0;
    int         nval2, nval3;

    logic line_q[$];
    int   edge_n;
    bit   armed[2], fell[2];
    int   r_c[2], f_c[2];
    int   e_high[2], e_per[2];
    bit   e_val[2], e_to[2], e_lv[2];

    always #5 clk = ~clk;

    drv_pwm_cap #(.p_depth(4), .p_sync(2)) u_dut2 (
        .i_clk(clk), .i_rst(rst), .i_drv_port(drv),
        .o_high(high2), .o_period(per2), .o_valid(val2), .o_timeout(to2), .o_level(lv2)
    );
    drv_pwm_cap #(.p_depth(4), .p_sync(3)) u_dut3 (
        .i_clk(clk), .i_rst(rst), .i_drv_port(drv),
        .o_high(high3), .o_period(per3), .o_valid(val3), .o_timeout(to3), .o_level(lv3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    // synchronized level in cycle c for a chain of ps stages; 0 before enough samples exist
    function automatic logic sv(input int ps, input int c);
        int i;
        i = c - ps + 1;
        return (i >= 1) ? line_q[i-1] : 1'b0;
    endfunction

    task automatic model_reset();
        line_q.delete();
        edge_n = 0;
        for (int k = 0; k < 2; k++) begin
            armed[k] = 0; fell[k] = 0; r_c[k] = 0; f_c[k] = 0;
            e_high[k] = 0; e_per[k] = 0; e_val[k] = 0; e_to[k] = 0; e_lv[k] = 0;
        end
    endtask

    task automatic model_step();
        logic s, sp;
        int   c;
        line_q.push_back(drv);
        edge_n++;
        c = edge_n - 1;
        for (int k = 0; k < 2; k++) begin
            s  = sv(k + 2, c);
            sp = sv(k + 2, c - 1);
            e_val[k] = 0;
            if (!armed[k]) begin
                if (s && !sp) begin armed[k] = 1; r_c[k] = c; fell[k] = 0; end
            end else if (s && !sp) begin
                e_per[k] = c - r_c[k]; e_high[k] = f_c[k] - r_c[k];
                e_val[k] = 1; e_to[k] = 0; r_c[k] = c; fell[k] = 0;
            end else if (c - r_c[k] == c_tmo) begin
                e_to[k] = 1; e_lv[k] = s; armed[k] = 0;
            end else if (!s && sp && !fell[k]) begin
                fell[k] = 1; f_c[k] = c;
            end
        end
    endtask

    task automatic cmp_all();
        chk("high_s2", high2, e_high[0]);  chk("period_s2", per2, e_per[0]);
        chk("valid_s2", val2, e_val[0]);   chk("timeout_s2", to2, e_to[0]);
        chk("level_s2", lv2, e_lv[0]);
        chk("high_s3", high3, e_high[1]);  chk("period_s3", per3, e_per[1]);
        chk("valid_s3", val3, e_val[1]);   chk("timeout_s3", to3, e_to[1]);
        chk("level_s3", lv3, e_lv[1]);
    endtask

    task automatic cyc(input logic v);
        drv = v;
        @(posedge clk);
        model_step();
        @(negedge clk);
        cmp_all();
        if (val2) nval2++;
        if (val3) nval3++;
    endtask

    task automatic pulse(input int h, input int l);
        repeat (h) cyc(1'b1);
        repeat (l) cyc(1'b0);
    endtask

    // asserted between clock edges so the asynchronous clear is observed without an edge
    task automatic do_reset(input logic v);
        rst = 1'b1;
        drv = v;
        model_reset();
        #1 cmp_all();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        nval2 = 0;
        nval3 = 0;
    endtask

    initial begin
        int lat2, lat3;
        logic lvl;
        @(negedge clk);
        do_reset(1'b0);
        repeat (4) pulse(9, 5);
        pulse(9, 0);
        chk("t1_high", high2, 9);
        chk("t1_period", per2, 14);
        chk("t1_nvalid", nval2, 4);
        chk("t1_timeout", to2, 0);

        do_reset(1'b1);
        repeat (20) cyc(1'b1);
        repeat (4) cyc(1'b0);
        nval2 = 0;
        repeat (4) pulse(3, 4);
        chk("t2_high", high2, 3);
        chk("t2_period", per2, 7);
        chk("t2_nvalid", nval2, 3);

        do_reset(1'b0);
        repeat (3) cyc(1'b0);
        repeat (20) cyc(1'b1);
        chk("t3_timeout", to2, 1);
        chk("t3_level", lv2, 1);
        chk("t3_nvalid", nval2, 0);
        repeat (2) cyc(1'b0);
        repeat (3) pulse(2, 2);
        chk("t3_high", high2, 2);
        chk("t3_period", per2, 4);
        chk("t3_timeout_clr", to2, 0);

        repeat (20) cyc(1'b0);
        chk("t4_timeout", to2, 1);
        chk("t4_level", lv2, 0);
        chk("t4_high_hold", high2, 2);
        chk("t4_period_hold", per2, 4);

        repeat (2) pulse(4, 3);
        pulse(4, 2);
        chk("t5_pre_period", per2, 7);
        rst = 1'b1;
        #1;
        chk("t5_async_high", high2, 0);
        chk("t5_async_period", per2, 0);
        chk("t5_async_timeout", to2, 0);
        do_reset(1'b0);
        pulse(3, 3);
        repeat (4) cyc(1'b0);
        chk("t5_rearm_nvalid", nval2, 0);

        do_reset(1'b0);
        repeat (3) cyc(1'b0);
        pulse(3, 3);
        lat2 = 0;
        lat3 = 0;
        for (int k = 1; k <= 10; k++) begin
            cyc(1'b1);
            if (val2 && lat2 == 0) lat2 = k;
            if (val3 && lat3 == 0) lat3 = k;
        end
        chk("t6_latency_s2", lat2, 3);
        chk("t6_latency_s3", lat3, 4);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                do_reset(1'($urandom_range(0, 1)));
            end else if ($urandom_range(0, 19) == 0) begin
                lvl = 1'($urandom_range(0, 1));
                repeat ($urandom_range(18, 25)) cyc(lvl);
            end else begin
                pulse($urandom_range(1, 7), $urandom_range(1, 7));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
